// File: rtl/alu181_serial_pkg.sv
// Shared constants, FSM state type and parameter legality check for the
// serial 74181-style ALU.
package alu181_serial_pkg;

    localparam logic ALU_M_LOGIC = 1'b1;
    localparam logic ALU_M_ARITH = 1'b0;

    localparam logic [3:0] S_ADD = 4'd9;
    localparam logic [3:0] S_SUB = 4'd6;
    localparam logic [3:0] S_DEC = 4'd15;
    localparam logic [3:0] S_DBL = 4'd12;
    localparam logic [3:0] S_XOR = 4'd6;
    localparam logic [3:0] S_AND = 4'd11;
    localparam logic [3:0] S_OR  = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic bit params_legal(int unsigned data_w, int unsigned nib_per_cyc);
        return (data_w >= 4) && (data_w % 4 == 0) && (nib_per_cyc >= 1) &&
               ((data_w / 4) % nib_per_cyc == 0);
    endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-style slice: logic or arithmetic on one nibble,
// with carry-out and carry-into-bit-3 for overflow detection.
module alu181_slice
    import alu181_serial_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f4,
    output logic       c_out,
    output logic       c_msb_in
);

    logic [3:0] u;
    logic [3:0] v;
    logic [4:0] sum;

    always_comb begin
        u   = a4 | ({4{s[0]}} & b4) | ({4{s[1]}} & ~b4);
        v   = ({4{s[2]}} & a4 & ~b4) | ({4{s[3]}} & a4 & b4);
        sum = {1'b0, u} + {1'b0, v} + {4'b0, c_in};
        if (m == ALU_M_LOGIC) begin
            f4       = ~(u ^ v);
            c_out    = 1'b0;
            c_msb_in = 1'b0;
        end else begin
            f4       = sum[3:0];
            c_out    = sum[4];
            // carry into bit 3 recovered from the sum bit and its two addends
            c_msb_in = sum[3] ^ u[3] ^ v[3];
        end
    end

endmodule

// File: rtl/alu181_serial.sv
// Sequential DATA_W-bit 74181-style ALU: evaluates NIB_PER_CYC nibbles per
// clock, LSB first, with a registered carry between cycles.
module alu181_serial
    import alu181_serial_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NIB_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              m,
    input  logic [3:0]        s,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] f,
    output logic              cout,
    output logic              ovf,
    output logic              zero,
    output logic              aeqb
);

    localparam int unsigned GW    = 4 * NIB_PER_CYC;
    localparam int unsigned N_GRP = DATA_W / GW;
    localparam int unsigned IDX_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_GRP - 1);

    if (!params_legal(DATA_W, NIB_PER_CYC)) begin : g_bad_params
        $error("alu181_serial: DATA_W must be a multiple of 4 and NIB_PER_CYC must divide DATA_W/4");
    end

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    f_q;
    logic [DATA_W-1:0]    f_next;
    logic                 m_q;
    logic [3:0]           s_q;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx;
    logic                 cout_q;
    logic                 ovf_q;
    logic                 zero_q;
    logic                 aeqb_q;
    logic [GW-1:0]        a_grp;
    logic [GW-1:0]        b_grp;
    logic [GW-1:0]        f_grp;
    logic [NIB_PER_CYC:0] c_chain;
    logic                 c_msb_top;
    logic                 last_grp;

    assign last_grp = (idx == LAST_IDX);
    assign a_grp    = a_q[GW * 32'(idx) +: GW];
    assign b_grp    = b_q[GW * 32'(idx) +: GW];
    assign c_chain[0] = carry_q;

    for (genvar k = 0; k < NIB_PER_CYC; k++) begin : g_slice
        if (k == NIB_PER_CYC - 1) begin : g_top
            alu181_slice u_slice (
                .a4       (a_grp[4*k +: 4]),
                .b4       (b_grp[4*k +: 4]),
                .s        (s_q),
                .m        (m_q),
                .c_in     (c_chain[k]),
                .f4       (f_grp[4*k +: 4]),
                .c_out    (c_chain[k+1]),
                .c_msb_in (c_msb_top)
            );
        end else begin : g_low
            logic c_msb_unused;
            alu181_slice u_slice (
                .a4       (a_grp[4*k +: 4]),
                .b4       (b_grp[4*k +: 4]),
                .s        (s_q),
                .m        (m_q),
                .c_in     (c_chain[k]),
                .f4       (f_grp[4*k +: 4]),
                .c_out    (c_chain[k+1]),
                .c_msb_in (c_msb_unused)
            );
        end
    end

    always_comb begin
        f_next = f_q;
        f_next[GW * 32'(idx) +: GW] = f_grp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_grp) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            m_q     <= 1'b0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            aeqb_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= m;
                        s_q     <= s;
                        carry_q <= (m == ALU_M_LOGIC) ? 1'b0 : cin;
                        idx     <= '0;
                    end
                end
                ST_RUN: begin
                    f_q     <= f_next;
                    carry_q <= c_chain[NIB_PER_CYC];
                    // wrap to zero so idx never addresses past the top group
                    idx     <= last_grp ? '0 : idx + 1'b1;
                    if (last_grp) begin
                        cout_q <= c_chain[NIB_PER_CYC];
                        ovf_q  <= c_chain[NIB_PER_CYC] ^ c_msb_top;
                        zero_q <= (f_next == '0);
                        aeqb_q <= &f_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign f    = f_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign aeqb = aeqb_q;

endmodule

// File: tb/tb_alu181_serial.sv
// Self-checking bench for alu181_serial: four configurations checked against
// a whole-word arithmetic model, plus directed literal cases on the 16x1 one.
module tb_alu181_serial;
    import alu181_serial_pkg::*;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_v  [NI];
    logic        in_ready_v  [NI];
    logic        out_valid_v [NI];
    logic        out_ready_v [NI];
    logic        m_v         [NI];
    logic        cin_v       [NI];
    logic        cout_v      [NI];
    logic        ovf_v       [NI];
    logic        zero_v      [NI];
    logic        aeqb_v      [NI];
    logic [3:0]  s_v         [NI];
    logic [15:0] a_v         [NI];
    logic [15:0] b_v         [NI];
    logic [15:0] f_w         [3];
    logic [3:0]  f3;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [15:0] f;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        aeqb;
        int          inst;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];
    bit   lat_seen [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu181_serial #(.DATA_W(16), .NIB_PER_CYC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .m(m_v[0]), .s(s_v[0]), .cin(cin_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .f(f_w[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]), .aeqb(aeqb_v[0]));

    alu181_serial #(.DATA_W(16), .NIB_PER_CYC(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .m(m_v[1]), .s(s_v[1]), .cin(cin_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .f(f_w[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]), .aeqb(aeqb_v[1]));

    alu181_serial #(.DATA_W(16), .NIB_PER_CYC(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .m(m_v[2]), .s(s_v[2]), .cin(cin_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .f(f_w[2]),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]), .aeqb(aeqb_v[2]));

    alu181_serial #(.DATA_W(4), .NIB_PER_CYC(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3][3:0]), .b(b_v[3][3:0]), .m(m_v[3]), .s(s_v[3]), .cin(cin_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .f(f3),
        .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]), .aeqb(aeqb_v[3]));

    function automatic int unsigned dw_of(int i);
        return (i == 3) ? 4 : 16;
    endfunction

    function automatic int unsigned ngrp_of(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] f_of(int i);
        return (i == 3) ? {12'h000, f3} : f_w[i];
    endfunction

    // Packs result and handshake state: {f, in_ready, out_valid, cout, ovf, zero, aeqb}
    function automatic logic [31:0] pack(logic [15:0] fv, logic ir, logic ov,
                                         logic c, logic o, logic z, logic e);
        return {10'h000, fv, ir, ov, c, o, z, e};
    endfunction

    function automatic logic [31:0] dut_vec(int i);
        return pack(f_of(i), in_ready_v[i], out_valid_v[i], cout_v[i], ovf_v[i],
                    zero_v[i], aeqb_v[i]);
    endfunction

    // Whole-word reference: f = U + V + cin (or ~(U^V)), flags from plain integer arithmetic
    function automatic exp_t model(int unsigned dw, logic [15:0] a, logic [15:0] b,
                                   logic m, logic [3:0] s, logic cin);
        exp_t        r;
        int unsigned mask;
        int unsigned half;
        int unsigned u;
        int unsigned v;
        int unsigned sum;
        int unsigned cmsb;
        mask = (32'd1 << dw) - 1;
        half = mask >> 1;
        u = 32'(a | (s[0] ? b : 16'h0) | (s[1] ? ~b : 16'h0)) & mask;
        v = 32'((s[2] ? (a & ~b) : 16'h0) | (s[3] ? (a & b) : 16'h0)) & mask;
        r.inst = 0;
        r.acc  = 0;
        if (m) begin
            r.f    = 16'(~(u ^ v) & mask);
            r.cout = 1'b0;
            r.ovf  = 1'b0;
        end else begin
            sum    = u + v + 32'(cin);
            r.f    = 16'(sum & mask);
            r.cout = ((sum >> dw) & 32'd1) != 0;
            cmsb   = ((u & half) + (v & half) + 32'(cin)) >> (dw - 1);
            r.ovf  = r.cout ^ cmsb[0];
        end
        r.zero = (r.f == 16'h0);
        r.aeqb = (32'(r.f) == mask);
        return r;
    endfunction

    task automatic check_vec(input string name, input int i,
                             input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h required %h (f,ir,ov,c,o,z,e) t=%0t",
                     name, i, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int   j;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < NI; i++) lat_seen[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_valid_v[i] && in_ready_v[i]) begin
                    e = model(dw_of(i), a_v[i], b_v[i], m_v[i], s_v[i], cin_v[i]);
                    e.inst = i;
                    e.acc  = cyc;
                    sb.push_back(e);
                end
                if (out_valid_v[i]) begin
                    j = -1;
                    for (int q = 0; q < sb.size(); q++) begin
                        if (sb[q].inst == i && j < 0) j = q;
                    end
                    if (j < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out inst%0d: out_valid=1 required 0", i);
                    end else begin
                        check_vec("result", i, dut_vec(i),
                                  pack(sb[j].f, 1'b0, 1'b1, sb[j].cout, sb[j].ovf,
                                       sb[j].zero, sb[j].aeqb));
                        if (!lat_seen[i]) begin
                            lat_seen[i] = 1'b1;
                            check_vec("latency", i, cyc - sb[j].acc, ngrp_of(i) + 1);
                        end
                        if (out_ready_v[i]) begin
                            sb.delete(j);
                            lat_seen[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic [3:0] s, input logic cin);
        int k = 0;
        @(negedge clk);
        while (!in_ready_v[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_vec("issue_ready", i, 32'(in_ready_v[i]), 32'd1);
        @(posedge clk); #1;
        a_v[i] = a; b_v[i] = b; m_v[i] = m; s_v[i] = s; cin_v[i] = cin;
        in_valid_v[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
        a_v[i]   = 16'($urandom);
        b_v[i]   = 16'($urandom);
        m_v[i]   = 1'($urandom);
        s_v[i]   = 4'($urandom);
        cin_v[i] = 1'($urandom);
    endtask

    task automatic wait_valid(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (out_valid_v[i]) ok = 1'b1;
        end
        check_vec("wait_valid", i, 32'(ok), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [3:0] s, input logic cin, input logic [15:0] ef,
                         input logic ec, input logic eo, input logic ez, input logic ee);
        bit ok;
        out_ready_v[0] = 1'b1;
        issue(0, a, b, m, s, cin);
        wait_valid(0, ok);
        if (ok) check_vec("directed", 0, dut_vec(0), pack(ef, 1'b0, 1'b1, ec, eo, ez, ee));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_all(input string name);
        for (int i = 0; i < NI; i++) begin
            check_vec(name, i, dut_vec(i), pack(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic rand_drive(input int i);
        bit          done;
        logic [5:0]  code;
        logic [15:0] ra;
        logic [15:0] rb;
        for (int n = 0; n < 128; n++) begin
            code = 6'(n);
            ra   = 16'($urandom);
            rb   = (n % 8 == 0) ? ra : 16'($urandom);
            issue(i, ra, rb, code[5], code[4:1], code[0]);
            done = 1'b0;
            for (int k = 0; k < 200 && !done; k++) begin
                out_ready_v[i] = ($urandom_range(3) != 0);
                @(negedge clk);
                if (out_valid_v[i] && out_ready_v[i]) done = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check_vec("rand_handshake", i, 32'(done), 32'd1);
            @(posedge clk); #1;
            out_ready_v[i] = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < NI; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; m_v[i] = 1'b0;
            cin_v[i] = 1'b0; s_v[i] = 4'h0; a_v[i] = 16'h0; b_v[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_all("reset_state");

        do_op(16'h1234, 16'h00FF, ALU_M_ARITH, S_ADD, 1'b0, 16'h1333, 0, 0, 0, 0);
        do_op(16'hFFFF, 16'h0001, ALU_M_ARITH, S_ADD, 1'b0, 16'h0000, 1, 0, 1, 0);
        do_op(16'h7FFF, 16'h0001, ALU_M_ARITH, S_ADD, 1'b0, 16'h8000, 0, 1, 0, 0);
        do_op(16'h0005, 16'h0005, ALU_M_ARITH, S_SUB, 1'b0, 16'hFFFF, 0, 0, 0, 1);
        do_op(16'h0005, 16'h0005, ALU_M_ARITH, S_SUB, 1'b1, 16'h0000, 1, 0, 1, 0);
        do_op(16'hF0F0, 16'hFF00, ALU_M_LOGIC, S_XOR, 1'b1, 16'h0FF0, 0, 0, 0, 0);
        do_op(16'hF0F0, 16'hFF00, ALU_M_LOGIC, S_AND, 1'b1, 16'hF000, 0, 0, 0, 0);
        do_op(16'h0F0F, 16'h00F0, ALU_M_LOGIC, S_OR,  1'b0, 16'h0FFF, 0, 0, 0, 0);
        do_op(16'h0000, 16'h1234, ALU_M_ARITH, S_DEC, 1'b0, 16'hFFFF, 0, 0, 0, 1);
        do_op(16'h4000, 16'h0000, ALU_M_ARITH, S_DBL, 1'b0, 16'h8000, 0, 1, 0, 0);

        out_ready_v[0] = 1'b0;
        issue(0, 16'hF0F0, 16'hFF00, ALU_M_LOGIC, S_XOR, 1'b1);
        wait_valid(0, ok);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check_vec("backpressure", 0, dut_vec(0), pack(16'h0FF0, 0, 1, 0, 0, 0, 0));
        end
        @(posedge clk); #1 out_ready_v[0] = 1'b1;
        @(posedge clk); #1;

        issue(0, 16'h1111, 16'h2222, ALU_M_ARITH, S_ADD, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_all("reset_mid_run");
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(16'h1111, 16'h2222, ALU_M_ARITH, S_ADD, 1'b0, 16'h3333, 0, 0, 0, 0);

        fork
            rand_drive(0);
            rand_drive(1);
            rand_drive(2);
            rand_drive(3);
        join

        repeat (3) @(negedge clk);
        check_vec("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu181_serial.md
Name: alu181_serial

Overview:
- Parametrised, sequential successor to the team's 4-bit 74181-style ALU.
- Operates on DATA_W-bit operands and covers the full 32-function 74181 set (M, S[3:0], carry-in).
- Computes NIB_PER_CYC 4-bit slices per clock, LSB slice first, with a registered carry chain between cycles.
- Uses valid/ready handshakes on both sides, so it can sit in the datapath behind the register file and ahead of writeback.

Parameters:
- DATA_W, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB_PER_CYC, 1, 4-bit slices evaluated per clock; must divide DATA_W/4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- m  in  1  mode: 1 = logic, 0 = arithmetic.
- s  in  4  function select.
- cin  in  1  carry-in, active-high (1 adds one).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- f  out  DATA_W  result.
- cout  out  1  carry-out of the MSB.
- ovf  out  1  signed overflow.
- zero  out  1  f equals 0.
- aeqb  out  1  f is all ones (74181 A=B output).

Behaviour:
- Per-bit terms:
  - U = a | (s[0] & b) | (s[1] & ~b)
  - V = (s[2] & a & ~b) | (s[3] & a & b)
- Logic mode (m=1):
  - f = ~(U ^ V).
  - No carries; cout=0, ovf=0.
- Arithmetic mode (m=0):
  - f = (U + V + cin) mod 2^DATA_W.
  - cout = bit DATA_W of the full sum.
  - ovf = carry into the MSB XOR cout.
- Function checks:
  - m=0: s=9 gives A+B; s=6 gives A-B-1 (+cin); s=15 gives A-1; s=12 gives A+A.
  - m=1: s=6 gives XOR; s=11 gives AND; s=14 gives OR.
- zero and aeqb are evaluated over the full DATA_W result in both modes.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid is high, capture a, b, m, s; load the carry register with cin (0 if m=1); clear the slice index; go to RUN.
  - RUN: in_ready=0. Each cycle, compute slices idx..idx+NIB_PER_CYC-1 from the captured operands and the carry register; write those nibbles into the result register; update the carry register; advance idx. After the last slice group, latch cout/ovf/zero/aeqb and go to DONE.
  - DONE: out_valid=1; f and flags held stable. When out_ready is high, go to IDLE. No new request is accepted in the same cycle (in_ready=0 in DONE).
- Latency:
  - RUN lasts exactly N = DATA_W/(4*NIB_PER_CYC) cycles.
  - out_valid rises N+1 cycles after the accepting edge.
  - Throughput is one operation per N+2 cycles with out_ready held high.
- Backpressure: out_ready low in DONE holds state and outputs indefinitely.
- Input changes while in RUN or DONE are ignored, because operands are captured.
- Reset:
  - Asserting rst_n low at any time, including mid-RUN, forces IDLE.
  - Reset values: in_ready=1, out_valid=0, f=0, cout=0, ovf=0, zero=0, aeqb=0.
  - Internal carry, index and operand registers are cleared.
- DATA_W=4, NIB_PER_CYC=1 degenerates to one RUN cycle. Results must then match the single-slice combinational ALU.

Decomposition:
- Shared package: ALU_M_LOGIC/ALU_M_ARITH constants; named S-codes (S_ADD=9, S_SUB=6, S_DEC=15, S_DBL=12, S_XOR=6, S_AND=11, S_OR=14); FSM state enum; an elaboration-time parameter-legality check.
- Sub-module alu181_slice: combinational 4-bit slice.
  - Inputs a4, b4, s, m, c_in.
  - Outputs f4, c_out, c_msb_in (carry into bit 3, used for ovf on the top slice).
- Instantiate NIB_PER_CYC copies, chained combinationally within a cycle.

Test Plan:
- DATA_W=16: a=0x1234, b=0x00FF, m=0, s=9, cin=0 → f=0x1333, cout=0, ovf=0, zero=0; out_valid exactly 5 cycles after accept.
- a=0xFFFF, b=0x0001, m=0, s=9, cin=0 → f=0x0000, cout=1, zero=1. Then a=0x7FFF, b=0x0001 → f=0x8000, ovf=1, cout=0.
- Compare: a=b=0x0005, m=0, s=6, cin=0 → f=0xFFFF, aeqb=1, cout=0. Same operands with cin=1 → f=0x0000, zero=1, cout=1.
- Logic: a=0xF0F0, b=0xFF00, m=1, s=6, cin=1 → f=0x0FF0, cout=0, ovf=0. Same operands, s=11 → f=0xF000.
- Backpressure and reset:
  - Hold out_ready=0 for 7 cycles in DONE → f and flags stable, in_ready=0.
  - Then drop rst_n for one cycle in the middle of RUN of the next operation → in_ready=1, out_valid=0, f=0 immediately.
  - The following request completes correctly.
- Random regression with NIB_PER_CYC=1, 2 and 4 (DATA_W=16) plus DATA_W=4, all 32 M/S combinations and both cin values, against a behavioural model → bit-exact f/cout/ovf/zero/aeqb; latency = N+1.
